// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV immediate generator with PC target and 2-entry skid buffer
// One instruction per cycle in, FIFO-ordered immediates out; M drives outputs, K absorbs stalls.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit AUTO_FMT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [3:0]      select,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_U  = 3'b000;
  localparam logic [2:0] FMT_J  = 3'b001;
  localparam logic [2:0] FMT_I  = 3'b010;
  localparam logic [2:0] FMT_B  = 3'b011;
  localparam logic [2:0] FMT_S  = 3'b100;
  localparam logic [2:0] FMT_SH = 3'b101;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [2:0]      fmt;
  logic            fmt_bad;
  logic [XLEN-1:0] fill;
  logic [XLEN-1:0] new_imm;
  logic [XLEN-1:0] new_target;
  logic            new_illegal;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  always_comb begin
    fmt     = select[2:0];
    fmt_bad = 1'b0;
    if (AUTO_FMT) begin
      case (opcode)
        7'b0110111, 7'b0010111: fmt = FMT_U;
        7'b1101111:             fmt = FMT_J;
        7'b1100011:             fmt = FMT_B;
        7'b0100011:             fmt = FMT_S;
        7'b0010011:             fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
        7'b0000011, 7'b1100111: fmt = FMT_I;
        default: begin
          fmt     = FMT_I;
          fmt_bad = 1'b1;
        end
      endcase
    end
  end

  // Every format's sign bit is instruction[31], so one fill vector serves them all.
  always_comb begin
    fill        = select[3] ? '0 : {XLEN{instruction[31]}};
    new_imm     = fill;
    new_illegal = fmt_bad;
    case (fmt)
      FMT_U: new_imm[31:0] = {instruction[31:12], 12'b0};
      FMT_J: new_imm[20:0] = {instruction[31], instruction[19:12], instruction[20],
                              instruction[30:21], 1'b0};
      FMT_I: new_imm[11:0] = instruction[31:20];
      FMT_B: new_imm[12:0] = {instruction[31], instruction[7], instruction[30:25],
                              instruction[11:8], 1'b0};
      FMT_S: new_imm[11:0] = {instruction[31:25], instruction[11:7]};
      FMT_SH: begin
        new_imm = '0;
        if (XLEN == 64) new_imm[5:0] = instruction[25:20];
        else            new_imm[4:0] = instruction[24:20];
      end
      default: new_illegal = 1'b1;
    endcase
    if (new_illegal) new_imm = '0;
    new_target = pc + new_imm;
  end

  logic            m_valid, k_valid;
  logic [XLEN-1:0] m_imm, m_target, k_imm, k_target;
  logic            m_illegal, k_illegal;
  logic            accept, drain;
  logic            m_valid_nxt, k_valid_nxt;
  logic            load_m_from_k, load_m_from_in, load_k_from_in;

  assign accept = in_valid & in_ready;
  assign drain  = m_valid & out_ready;

  // K is only ever occupied while M is, so draining M always pulls K forward first.
  always_comb begin
    m_valid_nxt    = m_valid;
    k_valid_nxt    = k_valid;
    load_m_from_k  = 1'b0;
    load_m_from_in = 1'b0;
    load_k_from_in = 1'b0;
    if (!m_valid || drain) begin
      if (k_valid) begin
        load_m_from_k  = 1'b1;
        m_valid_nxt    = 1'b1;
        k_valid_nxt    = accept;
        load_k_from_in = accept;
      end else begin
        m_valid_nxt    = accept;
        load_m_from_in = accept;
      end
    end else if (accept) begin
      k_valid_nxt    = 1'b1;
      load_k_from_in = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid   <= 1'b0;
      k_valid   <= 1'b0;
      in_ready  <= 1'b1;
      m_imm     <= '0;
      m_target  <= '0;
      m_illegal <= 1'b0;
      k_imm     <= '0;
      k_target  <= '0;
      k_illegal <= 1'b0;
    end else if (flush) begin
      m_valid  <= 1'b0;
      k_valid  <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      m_valid  <= m_valid_nxt;
      k_valid  <= k_valid_nxt;
      in_ready <= !k_valid_nxt;
      if (load_m_from_k) begin
        m_imm     <= k_imm;
        m_target  <= k_target;
        m_illegal <= k_illegal;
      end else if (load_m_from_in) begin
        m_imm     <= new_imm;
        m_target  <= new_target;
        m_illegal <= new_illegal;
      end
      if (load_k_from_in) begin
        k_imm     <= new_imm;
        k_target  <= new_target;
        k_illegal <= new_illegal;
      end
    end
  end

  assign out_valid   = m_valid;
  assign out_imm     = m_imm;
  assign out_target  = m_target;
  assign out_illegal = m_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - bench for imm_gen_pipe (32-bit manual, 32-bit auto-format, 64-bit manual)
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic [3:0]  select;

  logic        rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, ill_a, ill_b, ill_c;
  logic [31:0] imm_a, tgt_a, imm_b, tgt_b;
  logic [63:0] imm_c, tgt_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  sel;
    logic [63:0] pc;
  } entry_t;
  entry_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_FMT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .instruction(instruction), .pc(pc[31:0]), .select(select), .out_valid(ov_a),
    .out_ready(out_ready), .out_imm(imm_a), .out_target(tgt_a), .out_illegal(ill_a));

  imm_gen_pipe #(.XLEN(32), .AUTO_FMT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .instruction(instruction), .pc(pc[31:0]), .select(select), .out_valid(ov_b),
    .out_ready(out_ready), .out_imm(imm_b), .out_target(tgt_b), .out_illegal(ill_b));

  imm_gen_pipe #(.XLEN(64), .AUTO_FMT(1'b0)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .instruction(instruction), .pc(pc), .select(select), .out_valid(ov_c),
    .out_ready(out_ready), .out_imm(imm_c), .out_target(tgt_c), .out_illegal(ill_c));

  function automatic int auto_fmt(input logic [31:0] ins);
    int f;
    case (ins[6:0])
      7'b0110111, 7'b0010111: f = 0;
      7'b1101111:             f = 1;
      7'b1100011:             f = 3;
      7'b0100011:             f = 4;
      7'b0010011:             f = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? 5 : 2;
      7'b0000011, 7'b1100111: f = 2;
      default:                f = 7;
    endcase
    return f;
  endfunction

  // Field value r of width w, sign-extended by subtracting 2^w when its top bit is set.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [3:0] sel,
                                          input int xlen, input bit auto_mode, output bit ill);
    int fmt;
    int w;
    bit sgn;
    logic [63:0] r, v;
    fmt = auto_mode ? auto_fmt(ins) : int'(sel[2:0]);
    ill = 1'b0;
    sgn = !sel[3];
    r   = '0;
    w   = 1;
    case (fmt)
      0: begin r = 64'(ins[31:12]) * 64'd4096; w = 32; end
      1: begin r = 64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); w = 21; end
      2: begin r = 64'(ins[31:20]); w = 12; end
      3: begin r = 64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); w = 13; end
      4: begin r = 64'({ins[31:25], ins[11:7]}); w = 12; end
      5: begin r = (xlen == 32) ? 64'(ins[24:20]) : 64'(ins[25:20]); w = 6; sgn = 1'b0; end
      default: begin ill = 1'b1; sgn = 1'b0; end
    endcase
    v = r;
    if (sgn && r[w-1]) v = r - (64'd1 << w);
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic cycle();
    bit          acc, drn, exp_ov, exp_rdy, la, lb, lc;
    logic [63:0] ea, eb, ec, ta, tb, tc;
    entry_t      e, e_in;
    exp_ov  = (q.size() > 0);
    exp_rdy = (q.size() < 2);
    checks++;
    if ({ov_a, ov_b, ov_c} !== {3{exp_ov}} || {rdy_a, rdy_b, rdy_c} !== {3{exp_rdy}}) begin
      errors++;
      $display("FAIL handshake: got out_valid=%b%b%b in_ready=%b%b%b, want out_valid=%b in_ready=%b",
               ov_a, ov_b, ov_c, rdy_a, rdy_b, rdy_c, exp_ov, exp_rdy);
    end
    drn = exp_ov && out_ready;
    acc = in_valid && exp_rdy;
    if (drn) begin
      e  = q[0];
      ea = ref_imm(e.ins, e.sel, 32, 1'b0, la);
      eb = ref_imm(e.ins, e.sel, 32, 1'b1, lb);
      ec = ref_imm(e.ins, e.sel, 64, 1'b0, lc);
      ta = (e.pc + ea) & 64'hFFFF_FFFF;
      tb = (e.pc + eb) & 64'hFFFF_FFFF;
      tc = e.pc + ec;
      checks++;
      if ({imm_a, tgt_a, ill_a} !== {ea[31:0], ta[31:0], la}) begin
        errors++;
        $display("FAIL out_a ins=%h sel=%b: got imm=%h tgt=%h ill=%b, want imm=%h tgt=%h ill=%b",
                 e.ins, e.sel, imm_a, tgt_a, ill_a, ea[31:0], ta[31:0], la);
      end
      checks++;
      if ({imm_b, tgt_b, ill_b} !== {eb[31:0], tb[31:0], lb}) begin
        errors++;
        $display("FAIL out_b ins=%h sel=%b: got imm=%h tgt=%h ill=%b, want imm=%h tgt=%h ill=%b",
                 e.ins, e.sel, imm_b, tgt_b, ill_b, eb[31:0], tb[31:0], lb);
      end
      checks++;
      if ({imm_c, tgt_c, ill_c} !== {ec, tc, lc}) begin
        errors++;
        $display("FAIL out_c ins=%h sel=%b: got imm=%h tgt=%h ill=%b, want imm=%h tgt=%h ill=%b",
                 e.ins, e.sel, imm_c, tgt_c, ill_c, ec, tc, lc);
      end
    end
    e_in.ins = instruction;
    e_in.sel = select;
    e_in.pc  = pc;
    @(posedge clk);
    #1;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e_in);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; pc = '0; select = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ov_a, ov_b, ov_c, ill_a, ill_b, ill_c} !== 6'b0 || {imm_a, tgt_a, imm_b, tgt_b} !== 128'b0 ||
        {imm_c, tgt_c} !== 128'b0 || {rdy_a, rdy_b, rdy_c} !== 3'b111) begin
      errors++;
      $display("FAIL reset_state: got ov=%b%b%b rdy=%b%b%b imm_a=%h imm_c=%h, want ov=000 rdy=111 imm=0",
               ov_a, ov_b, ov_c, rdy_a, rdy_b, rdy_c, imm_a, imm_c);
    end
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_i_type();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'hFFF00093; select = 4'b0010; pc = 64'h200;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (ov_a !== 1'b1 || imm_a !== 32'hFFFFFFFF || imm_b !== 32'hFFFFFFFF || imm_c !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++;
      $display("FAIL i_sext: got ov=%b imm_a=%h imm_b=%h imm_c=%h, want 1 ffffffff ffffffff ffffffffffffffff",
               ov_a, imm_a, imm_b, imm_c);
    end
    cycle();
    in_valid = 1'b1; select = 4'b1010;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (imm_a !== 32'h00000FFF || imm_c !== 64'h0000000000000FFF) begin
      errors++;
      $display("FAIL i_zext: got imm_a=%h imm_c=%h, want 00000fff", imm_a, imm_c);
    end
    cycle();
  endtask

  task automatic test_b_type();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'hFE000EE3; select = 4'b0011; pc = 64'h100;
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({imm_a, tgt_a} !== {32'hFFFFFFFC, 32'h000000FC} || {imm_b, tgt_b} !== {32'hFFFFFFFC, 32'h000000FC}) begin
      errors++;
      $display("FAIL b_type: got a=%h/%h b=%h/%h, want fffffffc/000000fc", imm_a, tgt_a, imm_b, tgt_b);
    end
    cycle();
    in_valid = 1'b1; select = 4'b0000;
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({imm_b, tgt_b, ill_b} !== {32'hFFFFFFFC, 32'h000000FC, 1'b0}) begin
      errors++;
      $display("FAIL b_auto: got %h/%h ill=%b, want fffffffc/000000fc ill=0", imm_b, tgt_b, ill_b);
    end
    cycle();
  endtask

  task automatic test_u_type_and_shamt();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h800000B7; select = 4'b0000; pc = 64'h0;
    cycle();
    checks++;
    if (imm_c !== 64'hFFFFFFFF80000000 || imm_a !== 32'h80000000) begin
      errors++;
      $display("FAIL u_sext: got imm_c=%h imm_a=%h, want ffffffff80000000 80000000", imm_c, imm_a);
    end
    select = 4'b1000;
    cycle();
    checks++;
    if (imm_c !== 64'h0000000080000000) begin
      errors++;
      $display("FAIL u_zext: got imm_c=%h, want 0000000080000000", imm_c);
    end
    instruction = 32'h03F01013; select = 4'b0101;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (imm_a !== 32'h1F || imm_b !== 32'h1F || imm_c !== 64'h3F) begin
      errors++;
      $display("FAIL shamt: got a=%h b=%h c=%h, want 1f 1f 3f", imm_a, imm_b, imm_c);
    end
    cycle();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h0; select = 4'b0110; pc = 64'h1234;
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({ill_a, ill_b, ill_c} !== 3'b111 || {imm_a, imm_b} !== 64'b0 || imm_c !== 64'b0 ||
        tgt_a !== 32'h1234 || tgt_b !== 32'h1234 || tgt_c !== 64'h1234) begin
      errors++;
      $display("FAIL illegal: got ill=%b%b%b imm_a=%h tgt_a=%h tgt_c=%h, want 111 0 1234 1234",
               ill_a, ill_b, ill_c, imm_a, tgt_a, tgt_c);
    end
    cycle();
  endtask

  task automatic test_back_pressure();
    int seen;
    out_ready = 1'b0; select = 4'b0010; pc = 64'h40; in_valid = 1'b1;
    instruction = 32'h00100013;
    cycle();
    instruction = 32'h00200013;
    cycle();
    instruction = 32'h00300013;
    cycle();
    checks++;
    if (rdy_a !== 1'b0 || ov_a !== 1'b1 || imm_a !== 32'h1) begin
      errors++;
      $display("FAIL bp_hold: got in_ready=%b ov=%b imm=%h, want 0 1 00000001", rdy_a, ov_a, imm_a);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (ov_a === 1'b1) seen++;
      cycle();
      if (i == 1) in_valid = 1'b0;
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL bp_drain: got %0d valid cycles, want 3", seen);
    end
    cycle();
  endtask

  task automatic test_flush_and_reset();
    out_ready = 1'b0; select = 4'b0100; pc = 64'h80; in_valid = 1'b1;
    instruction = 32'h00A12223;
    cycle();
    instruction = 32'hFE112E23;
    cycle();
    flush = 1'b1; instruction = 32'h00000013;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({ov_a, ov_b, ov_c} !== 3'b000 || {rdy_a, rdy_b, rdy_c} !== 3'b111) begin
      errors++;
      $display("FAIL flush: got ov=%b%b%b rdy=%b%b%b, want 000 111", ov_a, ov_b, ov_c, rdy_a, rdy_b, rdy_c);
    end
    out_ready = 1'b1;
    repeat (4) cycle();
    out_ready = 1'b0; in_valid = 1'b1; instruction = 32'hFFF00093; select = 4'b0010;
    cycle();
    cycle();
    reset = 1'b1; flush = 1'b1;
    cycle();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({ov_a, ov_b, ov_c, ill_a, ill_b, ill_c} !== 6'b0 || {imm_a, tgt_a, imm_b, tgt_b} !== 128'b0 ||
        {imm_c, tgt_c} !== 128'b0 || {rdy_a, rdy_b, rdy_c} !== 3'b111) begin
      errors++;
      $display("FAIL midstream_reset: got ov=%b%b%b imm_a=%h tgt_a=%h imm_c=%h, want all 0, rdy=111",
               ov_a, ov_b, ov_c, imm_a, tgt_a, imm_c);
    end
    out_ready = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_random();
    logic [6:0] ops [0:8];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011, 7'b0100011,
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0000000};
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      instruction = $urandom;
      if ($urandom_range(0, 1) == 1) instruction[6:0] = ops[$urandom_range(0, 8)];
      select      = 4'($urandom_range(0, 15));
      pc          = {$urandom, $urandom};
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_b_type();
    test_u_type_and_shamt();
    test_illegal();
    test_back_pressure();
    test_flush_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
